mem_wb_pipe_reg: RTL and testbench
==================================

Name: mem_wb_pipe_reg

Overview:
Parametrised MEM/WB pipeline register for the N-issue superscalar core. It generalises the fixed dual-lane MEM/WB latch to LANES lanes and XLEN data width. It adds a valid/ready handshake with a 2-entry skid buffer, so a writeback stall does not break MEM-stage timing. It also adds a synchronous flush and per-lane write-hazard hygiene, so the register file never sees a write to x0 or two same-bundle writes to one rd.

Parameters:
LANES, 2, number of issue lanes; lane 0 is oldest in program order.
XLEN, 32, data width of readdata/aluresult per lane.
REG_AW, 5, register-address width.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
flush  in  1  synchronous flush; drops all held and incoming bundles.
in_valid  in  1  MEM stage presents a bundle.
in_ready  out  1  register can accept a bundle; registered output.
in_readdata  in  LANES*XLEN  load data; lane i at [i*XLEN +: XLEN].
in_aluresult  in  LANES*XLEN  ALU result per lane.
in_rd  in  LANES*REG_AW  destination register per lane.
in_memtoreg  in  LANES  select load data for writeback.
in_regwrite  in  LANES  lane writes the register file.
out_valid  out  1  WB bundle valid.
out_ready  in  1  WB stage consumes the bundle.
out_readdata, out_aluresult, out_rd, out_memtoreg, out_regwrite  out  same widths as inputs  held bundle.

Behaviour:
- Reset (reset=0, async):
  - state=EMPTY, in_ready=1, out_valid=0.
  - All payload outputs and the skid entry clear to 0.
  - Reset mid-transfer discards everything.
- Transfers:
  - Accept = in_valid & in_ready.
  - Drain = out_valid & out_ready.
  - Latency is 1 cycle: a bundle accepted at edge k is visible on out_* after edge k when the register was empty.
- States (main = output register, skid = overflow register):
  - EMPTY: out_valid=0, in_ready=1. Accept → HALF, main←in.
  - HALF: out_valid=1, in_ready=1.
    - Accept & drain → HALF, main←in.
    - Accept & !drain → FULL, skid←in.
    - !accept & drain → EMPTY.
    - Neither → hold.
  - FULL: out_valid=1, in_ready=0. Drain → HALF, main←skid. Otherwise hold.
- Ordering: bundles leave in acceptance order; none are dropped or duplicated except by flush.
- Output stability: out_* are stable while out_valid & !out_ready.
- Flush:
  - Highest priority below reset: next state=EMPTY, out_valid=0, in_ready=1.
  - A bundle offered in the flush cycle is discarded. A drain in the same cycle still counts as consumed.
- Hygiene, applied at capture on the stored copy only:
  - regwrite[i] cleared when rd[i]==0.
  - regwrite[i] cleared when some j>i has regwrite[j]=1 and rd[j]==rd[i] (younger lane wins).
  - The data, rd and memtoreg fields pass through unmodified.
- in_valid=0: the payload is don't-care and never captured.
- LANES=1: hygiene reduces to the x0 rule only.

Optional Feature:
MEM_WB_WBDATA_EN.
- Defined: adds output out_wbdata (LANES*XLEN). Per lane it equals out_memtoreg[i] ? out_readdata : out_aluresult. It is computed before the register and stored, so it has the same timing and reset value (0) as the other outputs.
- Undefined: the port and its logic are absent; WB performs the mux itself.

Decomposition:
- Shared package pipe_pkg holds:
  - the LANES/XLEN/REG_AW defaults;
  - the state encoding (EMPTY=2'd0, HALF=2'd1, FULL=2'd2);
  - a lane-field slicing function.
- One natural sub-module, wb_lane_hygiene: combinational regwrite masking over LANES. It is reused by the future EX/MEM successor.

Test Plan:
- Reset: hold reset=0 with in_valid=1 → in_ready=1, out_valid=0, all out_*=0. Release reset → first accept appears one cycle later.
- Throughput: out_ready=1, 8 back-to-back bundles, aluresult=0x10..0x17 → out_valid continuously high from cycle 1; values appear in order with 1-cycle latency.
- Stall/skid: out_ready=0 for 3 cycles while in_valid=1 (A=0xA, B=0xB) → FULL, in_ready=0, out holds A. Release out_ready → A then B in order; in_ready returns to 1 the cycle after the first drain.
- Flush: in FULL, assert flush with a new bundle C offered → next cycle out_valid=0, in_ready=1; A, B and C never appear on out.
- Hygiene (LANES=2):
  - rd={5,5}, regwrite={1,1} → out_regwrite={lane1=1, lane0=0}.
  - rd={0,7}, regwrite={1,1} → lane0 regwrite=0, lane1=1.
  - Data fields unchanged in both cases.
- MEM_WB_WBDATA_EN: memtoreg={1,0}, readdata={0xDEAD,0x1}, aluresult={0x2,0xBEEF} → out_wbdata lane0=0xDEAD, lane1=0xBEEF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared defaults, state encoding and lane slicing helper for the pipeline registers.
package pipe_pkg;

   localparam int unsigned LANES_DEF  = 2;
   localparam int unsigned XLEN_DEF   = 32;
   localparam int unsigned REG_AW_DEF = 5;

   localparam int unsigned ST_W = 2;
   localparam logic [ST_W-1:0] ST_EMPTY = 2'd0;
   localparam logic [ST_W-1:0] ST_HALF  = 2'd1;
   localparam logic [ST_W-1:0] ST_FULL  = 2'd2;

   // Low bit index of a lane's field inside a flattened per-lane vector.
   function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
      return lane * width;
   endfunction

endpackage

// File: rtl/wb_lane_hygiene.sv
// Combinational regwrite masking: drops writes to x0 and older same-bundle writes to a shared rd.
module wb_lane_hygiene
   import pipe_pkg::*;
#(
   parameter int unsigned LANES  = LANES_DEF,
   parameter int unsigned REG_AW = REG_AW_DEF
) (
   input  logic [LANES*REG_AW-1:0] i_rd,
   input  logic [LANES-1:0]        i_regwrite,
   output logic [LANES-1:0]        o_regwrite_c
);

   always_comb begin
      o_regwrite_c = i_regwrite;
      for (int i = 0; i < int'(LANES); i++) begin
         if (i_rd[lane_lo(i, REG_AW) +: REG_AW] == '0) begin
            o_regwrite_c[i] = 1'b0;
         end
         // A younger lane writing the same rd wins.
         for (int j = i + 1; j < int'(LANES); j++) begin
            if (i_regwrite[j] && (i_rd[lane_lo(j, REG_AW) +: REG_AW] == i_rd[lane_lo(i, REG_AW) +: REG_AW])) begin
               o_regwrite_c[i] = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register: LANES-wide bundle, valid/ready with 2-entry skid, flush, write hygiene.
// Optional MEM_WB_WBDATA_EN adds a registered writeback-data mux output (out_wbdata).
module mem_wb_pipe_reg
   import pipe_pkg::*;
#(
   parameter int unsigned LANES  = LANES_DEF,
   parameter int unsigned XLEN   = XLEN_DEF,
   parameter int unsigned REG_AW = REG_AW_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*XLEN-1:0]   in_readdata,
   input  logic [LANES*XLEN-1:0]   in_aluresult,
   input  logic [LANES*REG_AW-1:0] in_rd,
   input  logic [LANES-1:0]        in_memtoreg,
   input  logic [LANES-1:0]        in_regwrite,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*XLEN-1:0]   out_readdata,
   output logic [LANES*XLEN-1:0]   out_aluresult,
   output logic [LANES*REG_AW-1:0] out_rd,
   output logic [LANES-1:0]        out_memtoreg,
`ifdef MEM_WB_WBDATA_EN
   output logic [LANES*XLEN-1:0]   out_wbdata,
`endif
   output logic [LANES-1:0]        out_regwrite
);

   localparam int unsigned DW = LANES * XLEN;
   localparam int unsigned RW = LANES * REG_AW;

   logic [ST_W-1:0] r_state;
   logic [ST_W-1:0] w_state_nxt;
   logic            r_in_ready;
   logic            r_out_valid;
   logic            w_in_ready_nxt;
   logic            w_out_valid_nxt;
   logic            w_accept;
   logic            w_drain;
   logic            w_load_main;
   logic            w_main_from_skid;
   logic            w_load_skid;

   logic [DW-1:0]    r_readdata, r_aluresult;
   logic [RW-1:0]    r_rd;
   logic [LANES-1:0] r_memtoreg, r_regwrite;
   logic [DW-1:0]    r_sk_readdata, r_sk_aluresult;
   logic [RW-1:0]    r_sk_rd;
   logic [LANES-1:0] r_sk_memtoreg, r_sk_regwrite;
   logic [LANES-1:0] w_regwrite_clean;

   assign w_accept = in_valid & r_in_ready;
   assign w_drain  = r_out_valid & out_ready;

   wb_lane_hygiene #(
      .LANES  (LANES),
      .REG_AW (REG_AW)
   ) u_hygiene (
      .i_rd         (in_rd),
      .i_regwrite   (in_regwrite),
      .o_regwrite_c (w_regwrite_clean)
   );

   // Next-state and load-control decode; flush overrides everything below reset.
   always_comb begin
      w_state_nxt      = r_state;
      w_load_main      = 1'b0;
      w_main_from_skid = 1'b0;
      w_load_skid      = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_state_nxt = ST_HALF;
               w_load_main = 1'b1;
            end
         end
         ST_HALF: begin
            if (w_accept && w_drain) begin
               w_load_main = 1'b1;
            end else if (w_accept) begin
               w_state_nxt = ST_FULL;
               w_load_skid = 1'b1;
            end else if (w_drain) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (w_drain) begin
               w_state_nxt      = ST_HALF;
               w_load_main      = 1'b1;
               w_main_from_skid = 1'b1;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
      if (flush) begin
         w_state_nxt = ST_EMPTY;
         w_load_main = 1'b0;
         w_load_skid = 1'b0;
      end
      w_in_ready_nxt  = (w_state_nxt != ST_FULL);
      w_out_valid_nxt = (w_state_nxt != ST_EMPTY);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_out_valid <= w_out_valid_nxt;
      end
   end

   logic [DW-1:0]    w_m_readdata, w_m_aluresult;
   logic [RW-1:0]    w_m_rd;
   logic [LANES-1:0] w_m_memtoreg, w_m_regwrite;

   assign w_m_readdata  = w_main_from_skid ? r_sk_readdata  : in_readdata;
   assign w_m_aluresult = w_main_from_skid ? r_sk_aluresult : in_aluresult;
   assign w_m_rd        = w_main_from_skid ? r_sk_rd        : in_rd;
   assign w_m_memtoreg  = w_main_from_skid ? r_sk_memtoreg  : in_memtoreg;
   assign w_m_regwrite  = w_main_from_skid ? r_sk_regwrite  : w_regwrite_clean;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_readdata     <= '0;
         r_aluresult    <= '0;
         r_rd           <= '0;
         r_memtoreg     <= '0;
         r_regwrite     <= '0;
         r_sk_readdata  <= '0;
         r_sk_aluresult <= '0;
         r_sk_rd        <= '0;
         r_sk_memtoreg  <= '0;
         r_sk_regwrite  <= '0;
      end else begin
         if (w_load_main) begin
            r_readdata  <= w_m_readdata;
            r_aluresult <= w_m_aluresult;
            r_rd        <= w_m_rd;
            r_memtoreg  <= w_m_memtoreg;
            r_regwrite  <= w_m_regwrite;
         end
         if (w_load_skid) begin
            r_sk_readdata  <= in_readdata;
            r_sk_aluresult <= in_aluresult;
            r_sk_rd        <= in_rd;
            r_sk_memtoreg  <= in_memtoreg;
            r_sk_regwrite  <= w_regwrite_clean;
         end
      end
   end

`ifdef MEM_WB_WBDATA_EN
   logic [DW-1:0] r_wbdata;
   logic [DW-1:0] w_m_wbdata;

   // Writeback mux evaluated on whatever is about to enter the main register.
   for (genvar g = 0; g < int'(LANES); g++) begin : g_wb
      assign w_m_wbdata[g*XLEN +: XLEN] = w_m_memtoreg[g] ? w_m_readdata[g*XLEN +: XLEN]
                                                          : w_m_aluresult[g*XLEN +: XLEN];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wbdata <= '0;
      end else if (w_load_main) begin
         r_wbdata <= w_m_wbdata;
      end
   end

   assign out_wbdata = r_wbdata;
`endif

   assign in_ready      = r_in_ready;
   assign out_valid     = r_out_valid;
   assign out_readdata  = r_readdata;
   assign out_aluresult = r_aluresult;
   assign out_rd        = r_rd;
   assign out_memtoreg  = r_memtoreg;
   assign out_regwrite  = r_regwrite;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Scoreboard bench for mem_wb_pipe_reg (LANES=2, XLEN=32): directed stimulus, decoupled monitor.
module tb_mem_wb_pipe_reg;

   typedef struct packed {
      logic [63:0] rdat;
      logic [63:0] alu;
      logic [9:0]  rd;
      logic [1:0]  m2r;
      logic [1:0]  rw;
      logic [63:0] wb;
   } bundle_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_readdata = '0;
   logic [63:0] in_aluresult = '0;
   logic [9:0]  in_rd = '0;
   logic [1:0]  in_memtoreg = '0;
   logic [1:0]  in_regwrite = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_readdata;
   logic [63:0] out_aluresult;
   logic [9:0]  out_rd;
   logic [1:0]  out_memtoreg;
   logic [1:0]  out_regwrite;
`ifdef MEM_WB_WBDATA_EN
   logic [63:0] out_wbdata;
`endif

   int      checks = 0;
   int      errors = 0;
   bundle_t exp_q[$];

   always #5 clk = ~clk;

   mem_wb_pipe_reg dut (
      .clk           (clk),
      .reset         (reset_n),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_readdata   (in_readdata),
      .in_aluresult  (in_aluresult),
      .in_rd         (in_rd),
      .in_memtoreg   (in_memtoreg),
      .in_regwrite   (in_regwrite),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_readdata  (out_readdata),
      .out_aluresult (out_aluresult),
      .out_rd        (out_rd),
      .out_memtoreg  (out_memtoreg),
`ifdef MEM_WB_WBDATA_EN
      .out_wbdata    (out_wbdata),
`endif
      .out_regwrite  (out_regwrite)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one bundle until accepted (bounded); expected output is queued on acceptance.
   task automatic send(input logic [63:0] rdat, input logic [63:0] alu, input logic [9:0] rd,
                       input logic [1:0] m2r, input logic [1:0] rw, input logic [1:0] erw,
                       input logic [63:0] ewb);
      bundle_t e;
      bit      done;
      in_valid     = 1'b1;
      in_readdata  = rdat;
      in_aluresult = alu;
      in_rd        = rd;
      in_memtoreg  = m2r;
      in_regwrite  = rw;
      e            = '{rdat: rdat, alu: alu, rd: rd, m2r: m2r, rw: erw, wb: ewb};
      done         = 1'b0;
      for (int t = 0; t < 20 && !done; t++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            exp_q.push_back(e);
            done = 1'b1;
         end
         tick();
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
      end
      in_valid = 1'b0;
   endtask

   // Monitor: every drain is compared against the oldest expected bundle.
   initial begin
      bundle_t e;
      bit      ok;
      forever begin
         @(negedge clk);
         if (reset_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_out: alu=%h rd=%h with empty scoreboard, required no output",
                        out_aluresult, out_rd);
            end else begin
               e  = exp_q.pop_front();
               ok = ({out_readdata, out_aluresult, out_rd, out_memtoreg, out_regwrite}
                     === {e.rdat, e.alu, e.rd, e.m2r, e.rw});
`ifdef MEM_WB_WBDATA_EN
               ok = ok && (out_wbdata === e.wb);
`endif
               if (!ok) begin
                  errors++;
                  $display("FAIL bundle: got rdat=%h alu=%h rd=%h m2r=%b rw=%b expected rdat=%h alu=%h rd=%h m2r=%b rw=%b",
                           out_readdata, out_aluresult, out_rd, out_memtoreg, out_regwrite,
                           e.rdat, e.alu, e.rd, e.m2r, e.rw);
               end
`ifdef MEM_WB_WBDATA_EN
               if (out_wbdata !== e.wb)
                  $display("FAIL wbdata: got %h expected %h", out_wbdata, e.wb);
`endif
            end
         end
      end
   end

   initial begin
      // Reset held with a bundle offered: nothing must be captured.
      in_valid     = 1'b1;
      in_aluresult = 64'h1234_5678_9ABC_DEF0;
      in_readdata  = 64'hFFFF_FFFF_FFFF_FFFF;
      in_rd        = 10'h3FF;
      in_memtoreg  = 2'b11;
      in_regwrite  = 2'b11;
      out_ready    = 1'b1;
      repeat (3) tick();
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_payload", 64'({out_readdata, out_aluresult, out_rd, out_memtoreg, out_regwrite} != '0), 64'd0);
      reset_n = 1'b1;
      send(64'h0, {32'h55, 32'h99}, {5'd2, 5'd1}, 2'b00, 2'b11, 2'b11, {32'h55, 32'h99});
      chk("first_accept_valid", 64'(out_valid), 64'd1);
      tick();

      // Throughput: eight back-to-back bundles with 1-cycle latency.
      for (int k = 0; k < 8; k++) begin
         send(64'h0, {32'h100 + 32'(k), 32'h10 + 32'(k)}, {5'(k + 9), 5'(k + 1)}, 2'b00, 2'b00, 2'b00,
              {32'h100 + 32'(k), 32'h10 + 32'(k)});
         chk("tput_out_valid", 64'(out_valid), 64'd1);
         chk("tput_latency", 64'(out_aluresult[31:0]), 64'h10 + 64'(k));
      end
      repeat (2) tick();

      // Stall: fill main and skid, hold, then drain in order.
      out_ready = 1'b0;
      send(64'h0, {32'h1A, 32'hA}, {5'd3, 5'd4}, 2'b00, 2'b00, 2'b00, {32'h1A, 32'hA});
      send(64'h0, {32'h1B, 32'hB}, {5'd5, 5'd6}, 2'b00, 2'b00, 2'b00, {32'h1B, 32'hB});
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_out_valid", 64'(out_valid), 64'd1);
      chk("full_holds_a", 64'(out_aluresult[31:0]), 64'hA);
      tick();
      chk("stall_holds_a", 64'(out_aluresult[31:0]), 64'hA);
      out_ready = 1'b1;
      tick();
      chk("ready_after_drain", 64'(in_ready), 64'd1);
      repeat (3) tick();

      // Flush while FULL with a new bundle C offered: all three vanish.
      out_ready = 1'b0;
      send(64'h0, {32'h2A, 32'hA}, 10'd0, 2'b00, 2'b00, 2'b00, {32'h2A, 32'hA});
      send(64'h0, {32'h2B, 32'hB}, 10'd0, 2'b00, 2'b00, 2'b00, {32'h2B, 32'hB});
      in_valid     = 1'b1;
      in_aluresult = {32'h2C, 32'hC};
      flush        = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      exp_q.delete();
      out_ready = 1'b1;
      repeat (4) tick();

      // Hygiene: same-rd younger wins, x0 dropped, distinct rds kept, non-writing younger ignored.
      send(64'h0, {32'h22, 32'h11}, {5'd5, 5'd5}, 2'b00, 2'b11, 2'b10, {32'h22, 32'h11});
      send({32'h44, 32'h33}, {32'h66, 32'h55}, {5'd7, 5'd0}, 2'b00, 2'b11, 2'b10, {32'h66, 32'h55});
      send(64'h0, {32'h88, 32'h77}, {5'd4, 5'd3}, 2'b00, 2'b11, 2'b11, {32'h88, 32'h77});
      send(64'h0, {32'hAA, 32'h99}, {5'd6, 5'd6}, 2'b00, 2'b01, 2'b01, {32'hAA, 32'h99});

      // Writeback mux: lane0 selects load data, lane1 the ALU result.
      send({32'h1, 32'hDEAD}, {32'hBEEF, 32'h2}, {5'd9, 5'd8}, 2'b01, 2'b11, 2'b11,
           {32'hBEEF, 32'hDEAD});
      repeat (5) tick();

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
